// File: rtl/gpi.sv
// General-purpose input block: synchronised, optionally debounced pins with
// polarity-selectable edge status, W1C clear and a level interrupt. Macro: GPI_DEBOUNCE_EN.
module gpi #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_en,
    input  logic       wr_en,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [6:0] gpi_pins,
    output logic       irq
);

    typedef enum logic [1:0] {
        REG_CFG  = 2'd0,
        REG_PIN  = 2'd1,
        REG_STAT = 2'd2,
        REG_POL  = 2'd3
    } reg_sel_e;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("gpi: DEBOUNCE_CYCLES must be in 1..255");
    end

    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] r_filt_prev;
    logic [6:0] r_stat;
    logic [6:0] r_pol;
    logic [1:0] r_cfg;      // {edge_enable, irq_enable} = CFG[7:6]
    logic       r_irq;

    logic [6:0] w_filt;
    logic [6:0] w_set;
    logic [6:0] w_clr;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpi_pins;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPI_DEBOUNCE_EN
    logic [7:0] r_cnt [7];
    logic [6:0] r_filt;

    // A pin must disagree with the filtered value for DEBOUNCE_CYCLES
    // consecutive cycles before the filtered bit follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                r_cnt[i] <= '0;
            end
            r_filt <= '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    // An edge qualifies when the new filtered level equals the polarity bit.
    assign w_set = {7{r_cfg[1]}} & (w_filt ^ r_filt_prev) & ~(w_filt ^ r_pol);
    assign w_clr = (wr_en && addr == REG_STAT) ? data_in[6:0] : 7'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_prev <= '0;
            r_stat      <= '0;
            r_pol       <= '0;
            r_cfg       <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_filt_prev <= w_filt;
            r_stat      <= (r_stat & ~w_clr) | w_set;
            r_irq       <= r_cfg[0] & (|r_stat);
            if (wr_en && addr == REG_CFG) begin
                r_cfg <= data_in[7:6];
            end
            if (wr_en && addr == REG_POL) begin
                r_pol <= data_in[6:0];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        data_out = 8'h00;
        if (rd_en) begin
            unique case (reg_sel_e'(addr))
                REG_CFG:  data_out = {r_cfg, 6'b0};
                REG_PIN:  data_out = {1'b0, w_filt};
                REG_STAT: data_out = {1'b0, r_stat};
                REG_POL:  data_out = {1'b0, r_pol};
                default:  data_out = 8'h00;
            endcase
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_gpi.sv
// Self-checking bench for gpi: register-access vector table plus directed
// pin/edge/W1C/reset sequences. Debounce corner cases run when GPI_DEBOUNCE_EN is set.
module tb_gpi;

    localparam int DB = 4;
`ifdef GPI_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    localparam logic [1:0] A_CFG  = 2'd0;
    localparam logic [1:0] A_PIN  = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_POL  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_en;
    logic       wr_en;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [6:0] gpi_pins;
    logic       irq;

    int total = 0;
    int bad   = 0;

    gpi #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .gpi_pins (gpi_pins),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Combinational read at the current (negedge-aligned) time; no edge consumed.
    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string name);
        rd_en = 1'b1;
        addr  = a;
        #1;
        check(name, data_out, exp);
        rd_en = 1'b0;
    endtask

    task automatic irq_chk(input logic exp, input string name);
        #1;
        check(name, {7'b0, irq}, {7'b0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        addr    = a;
        data_in = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        addr     = '0;
        data_in  = '0;
        gpi_pins = 7'h7F;

        vecs[0]  = '{1'b0, 1'b1, A_CFG,  8'h00, 8'h00, "cfg_rst"};
        vecs[1]  = '{1'b1, 1'b1, A_CFG,  8'hFF, 8'h00, "cfg_rdwr_pre"};
        vecs[2]  = '{1'b0, 1'b1, A_CFG,  8'h00, 8'hC0, "cfg_reserved"};
        vecs[3]  = '{1'b1, 1'b1, A_POL,  8'hFF, 8'h00, "pol_rdwr_pre"};
        vecs[4]  = '{1'b0, 1'b1, A_POL,  8'h00, 8'h7F, "pol_reserved"};
        vecs[5]  = '{1'b1, 1'b1, A_PIN,  8'h55, 8'h00, "pin_wr_pre"};
        vecs[6]  = '{1'b0, 1'b1, A_PIN,  8'h00, 8'h00, "pin_wr_ignored"};
        vecs[7]  = '{1'b0, 1'b0, A_CFG,  8'h00, 8'h00, "no_rd_zero"};
        vecs[8]  = '{1'b1, 1'b1, A_CFG,  8'h3F, 8'hC0, "cfg_rdwr_pre2"};
        vecs[9]  = '{1'b0, 1'b1, A_CFG,  8'h00, 8'h00, "cfg_cleared"};
        vecs[10] = '{1'b1, 1'b0, A_POL,  8'h00, 8'h00, "pol_wr0"};
        vecs[11] = '{1'b0, 1'b1, A_POL,  8'h00, 8'h00, "pol_zero"};
        vecs[12] = '{1'b0, 1'b1, A_STAT, 8'h00, 8'h00, "stat_zero"};

        // Reset with all pins high.
        tick(3);
        rd_chk(A_PIN, 8'h00, "rst_pin_during");
        rd_chk(A_STAT, 8'h00, "rst_stat_during");
        irq_chk(1'b0, "rst_irq_during");
        reset = 1'b0;
        rd_chk(A_STAT, 8'h00, "rst_stat");
        rd_chk(A_CFG, 8'h00, "rst_cfg");
        tick(LAT + 1);
        rd_chk(A_PIN, 8'h7F, "pin_after_rst");
        rd_chk(A_STAT, 8'h00, "stat_no_rst_edge");
        gpi_pins = 7'h00;
        tick(LAT + 1);
        rd_chk(A_PIN, 8'h00, "pin_low");

        // Register access table.
        for (int i = 0; i < 13; i++) begin
            wr_en   = vecs[i].wr;
            rd_en   = vecs[i].rd;
            addr    = vecs[i].a;
            data_in = vecs[i].d;
            #1;
            check(vecs[i].name, data_out, vecs[i].exp);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Rising edge on pin0 with exact latency.
        wr(A_CFG, 8'hC0);
        wr(A_POL, 8'h01);
        gpi_pins[0] = 1'b1;
        tick(LAT);
        rd_chk(A_PIN, 8'h01, "rise_pin");
        rd_chk(A_STAT, 8'h00, "rise_stat_early");
        tick(1);
        rd_chk(A_STAT, 8'h01, "rise_stat");
        irq_chk(1'b0, "rise_irq_early");
        tick(1);
        irq_chk(1'b1, "rise_irq");

        // Falling polarity on pin3.
        wr(A_STAT, 8'hFF);
        wr(A_POL, 8'h00);
        gpi_pins[3] = 1'b1;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h00, "pol_rise_ignored");
        gpi_pins[3] = 1'b0;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h08, "pol_fall_set");
        irq_chk(1'b1, "pol_irq");
        gpi_pins[3] = 1'b1;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h08, "pol_rise_hold");

        // W1C with simultaneous set.
        wr(A_STAT, 8'hFF);
        wr(A_POL, 8'h03);
        gpi_pins[0] = 1'b0;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h00, "w1c_fall_ignored");
        gpi_pins[1:0] = 2'b11;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h03, "w1c_stat03");
        gpi_pins[0] = 1'b0;
        tick(LAT + 2);
        gpi_pins[0] = 1'b1;
        tick(LAT);
        wr(A_STAT, 8'h01);
        rd_chk(A_STAT, 8'h03, "w1c_set_priority");
        wr(A_STAT, 8'h03);
        rd_chk(A_STAT, 8'h00, "w1c_clear");
        irq_chk(1'b1, "w1c_irq_lag");
        tick(1);
        irq_chk(1'b0, "w1c_irq_low");

        // Edge detection disabled: pins tracked, no status.
        wr(A_CFG, 8'h40);
        wr(A_POL, 8'h7F);
        gpi_pins = 7'h20;
        tick(LAT + 1);
        rd_chk(A_PIN, 8'h20, "dis_pin20");
        rd_chk(A_STAT, 8'h00, "dis_stat_a");
        gpi_pins = 7'h55;
        tick(LAT + 1);
        rd_chk(A_PIN, 8'h55, "dis_pin55");
        rd_chk(A_STAT, 8'h00, "dis_stat_b");
        irq_chk(1'b0, "dis_irq");

        // Clearing CFG[7] keeps STAT.
        gpi_pins = 7'h00;
        tick(LAT + 2);
        wr(A_CFG, 8'hC0);
        gpi_pins = 7'h40;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h40, "en_pin6");
        wr(A_CFG, 8'h40);
        tick(1);
        rd_chk(A_STAT, 8'h40, "dis_keeps_stat");
        irq_chk(1'b1, "dis_keeps_irq");

        // Reset in the middle of a pin change.
        wr(A_STAT, 8'hFF);
        wr(A_CFG, 8'hC0);
        gpi_pins = 7'h41;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(LAT + 2);
        rd_chk(A_STAT, 8'h00, "midrst_stat");
        rd_chk(A_PIN, 8'h41, "midrst_pin");
        irq_chk(1'b0, "midrst_irq");

`ifdef GPI_DEBOUNCE_EN
        // Short pulse is filtered; long pulse accepted exactly at cycle DB+2.
        wr(A_CFG, 8'hC0);
        wr(A_POL, 8'h04);
        gpi_pins[2] = 1'b1;
        tick(3);
        gpi_pins[2] = 1'b0;
        tick(8);
        rd_chk(A_PIN, 8'h41, "db_short_pin");
        rd_chk(A_STAT, 8'h00, "db_short_stat");
        gpi_pins[2] = 1'b1;
        tick(5);
        rd_chk(A_PIN, 8'h41, "db_long_early");
        tick(1);
        rd_chk(A_PIN, 8'h45, "db_long_pin");
        tick(1);
        rd_chk(A_STAT, 8'h04, "db_long_stat");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpi.md
GPI -- requirements
Module: gpi

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable cycles required to accept a pin change (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port rd_en  input  1  read strobe.
REQ-005 SHALL have port wr_en  input  1  write strobe.
REQ-006 SHALL have port addr  input  2  register select: 0 CFG, 1 PIN, 2 STAT, 3 POL.
REQ-007 SHALL have port data_in  input  8  write data.
REQ-008 SHALL have port data_out  output  8  read data.
REQ-009 SHALL have port gpi_pins  input  7  asynchronous external inputs.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL pass each gpi_pins bit through a 2-flop synchronizer; the second flop output is the synced value.
REQ-012 SHALL hold a 7-bit filtered pin value; this is the value readable at PIN (bits 6:0, bit 7 reads 0).
REQ-013 SHALL detect an edge on bit i when filtered[i] differs from its value on the previous cycle.
REQ-014 SHALL set STAT[i] on an edge of bit i only if CFG[7]=1 and the edge direction matches POL[i] (1 rising, 0 falling).
REQ-015 SHALL clear STAT[i] on a write to STAT with data_in[i]=1 (write-1-to-clear); bits written 0 are unchanged.
REQ-016 SHALL give set priority: a set and a clear of the same STAT bit in one cycle leaves it 1.
REQ-017 SHALL write CFG and POL with data_in on wr_en; CFG bits 5:0 and POL bit 7 are reserved, not stored, and read 0.
REQ-018 SHALL ignore writes to PIN.
REQ-019 SHALL drive data_out combinationally with the addressed register when rd_en=1, else 8'h00; reads have no side effects.
REQ-020 SHALL return the pre-write value when rd_en and wr_en target the same register in the same cycle.
REQ-021 SHALL register irq as CFG[6] AND OR-reduce(STAT), so irq follows a STAT change by exactly one cycle.
REQ-022 SHALL keep sampling and filtering pins while CFG[7]=0; clearing CFG[7] does not clear STAT.
REQ-023 SHALL never set STAT from the reset-to-first-sample transition: the edge-history register resets to 0 together with the filtered value.

Reset
REQ-024 SHALL, with reset=1 at a clock edge, clear synchronizers, filtered value, edge history, debounce counters, CFG, POL, STAT and irq to 0; data_out is 8'h00 unless rd_en=1.
REQ-025 SHALL abort any debounce in progress on reset, with no edge reported for the aborted change.

Configuration
REQ-026 SHALL, with GPI_DEBOUNCE_EN defined, give each pin an 8-bit counter: it increments while synced differs from filtered, resets to 0 when they are equal, and the filtered bit takes the synced value when the count reaches DEBOUNCE_CYCLES-1, with the counter then cleared.
REQ-027 SHALL, with GPI_DEBOUNCE_EN defined, have a pin-to-filtered latency of 2+DEBOUNCE_CYCLES cycles, and glitches shorter than DEBOUNCE_CYCLES synced cycles have no effect.
REQ-028 SHALL, without GPI_DEBOUNCE_EN, remove the counters; the filtered value equals the synced value with a pin-to-filtered latency of 2 cycles, and DEBOUNCE_CYCLES is unused.

Verification
REQ-029 SHALL cover reset: drive pins 7'h7F, pulse reset, read PIN/STAT/CFG -> PIN 8'h00 during reset, STAT 8'h00, CFG 8'h00, irq 0.
REQ-030 SHALL cover rising edge: CFG=8'hC0, POL=8'h01, pin0 0->1 -> STAT reads 8'h01 after the stated latency, and irq rises one cycle later.
REQ-031 SHALL cover polarity: POL=8'h00, pin3 1->0 -> STAT=8'h08; pin3 0->1 -> STAT stays 8'h08.
REQ-032 SHALL cover W1C with simultaneous set: STAT=8'h03, write 8'h01 in the same cycle as a new pin0 edge -> STAT=8'h03; write 8'h03 with no edge -> STAT=8'h00, irq 0 one cycle later.
REQ-033 SHALL cover debounce (GPI_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): a 3-cycle pin2 pulse gives no PIN or STAT change; a 6-cycle pulse makes PIN bit 2 = 1 at cycle 6.
REQ-034 SHALL cover disabled operation: CFG=8'h40, pin toggles -> PIN tracks the pin, STAT stays 8'h00, irq 0; a reset asserted mid-debounce leaves STAT=8'h00.
